// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: stall cause encoding and register file size.
package hazard_types;

  localparam int REG_COUNT = 32;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    LOAD_USE   = 2'd1,
    SCOREBOARD = 2'd2,
    STRUCT     = 2'd3
  } stall_cause_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue, operand, forwarding and multi-cycle writeback bundle between ID/EX and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int MAX_LONG = 4
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);

  logic                      issue_valid;
  logic [4:0]                issue_rd;
  logic                      issue_we;
  logic                      issue_long;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*5-1:0]      src_idx;
  logic [NUM_SRC*XLEN-1:0]   src_rf_data;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*5-1:0]      fwd_rd;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      long_done;
  logic [4:0]                long_rd;
  logic [XLEN-1:0]           long_data;
  logic [NUM_SRC*XLEN-1:0]   src_out;
  logic                      stall;
  logic [1:0]                stall_cause;
  logic [CNT_W-1:0]          long_count;
  logic [31:0]               stall_cycles;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_long,
    output src_valid, src_idx, src_rf_data,
    output fwd_valid, fwd_rd, fwd_ready, fwd_data,
    output long_done, long_rd, long_data,
    input  src_out, stall, stall_cause, long_count, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_long,
    input  src_valid, src_idx, src_rf_data,
    input  fwd_valid, fwd_rd, fwd_ready, fwd_data,
    input  long_done, long_rd, long_data,
    output src_out, stall, stall_cause, long_count, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_operand_select.sv
// One source operand: priority mux over x0, long writeback, scoreboard, forwarding stages and the register file.
module operand_select
  import hazard_types::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    src_valid,
  input  logic [4:0]              src_idx,
  input  logic [XLEN-1:0]         src_rf_data,
  input  logic [REG_COUNT-1:0]    pending,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    long_done,
  input  logic [4:0]              long_rd,
  input  logic [XLEN-1:0]         long_data,
  output logic [XLEN-1:0]         src_out,
  output logic                    sb_stall,
  output logic                    lu_stall
);

  logic fwd_hit;
  int   fwd_sel;

  // Scanning from the oldest stage down lets the youngest matching stage overwrite the selection.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_sel = 0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd[k*5 +: 5] == src_idx)) begin
        fwd_hit = 1'b1;
        fwd_sel = k;
      end
    end
  end

  always_comb begin
    src_out  = src_rf_data;
    sb_stall = 1'b0;
    lu_stall = 1'b0;
    if (src_idx == 5'd0) begin
      src_out = '0;
    end else if (long_done && (long_rd == src_idx)) begin
      src_out = long_data;
    end else if (pending[src_idx]) begin
      sb_stall = src_valid;
    end else if (fwd_hit) begin
      if (fwd_ready[fwd_sel]) begin
        src_out = fwd_data[fwd_sel*XLEN +: XLEN];
      end else begin
        lu_stall = src_valid;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding plus a pending-register scoreboard for multi-cycle results, with stall arbitration and a stall counter.
module hazard_scoreboard
  import hazard_types::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int MAX_LONG = 4
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);

  logic [REG_COUNT-1:0] pending_q;
  logic [REG_COUNT-1:0] pending_d;
  logic [CNT_W-1:0]     long_count_q;
  logic [31:0]          stall_cycles_q;

  logic [XLEN-1:0] operand [NUM_SRC];
  logic            sb_hit  [NUM_SRC];
  logic            lu_hit  [NUM_SRC];

  logic         any_sb;
  logic         any_lu;
  logic         waw;
  logic         struct_hit;
  logic         acc;
  logic         ret;
  stall_cause_t cause;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    operand_select #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD)
    ) u_sel (
      .src_valid   (bus.src_valid[i]),
      .src_idx     (bus.src_idx[i*5 +: 5]),
      .src_rf_data (bus.src_rf_data[i*XLEN +: XLEN]),
      .pending     (pending_q),
      .fwd_valid   (bus.fwd_valid),
      .fwd_rd      (bus.fwd_rd),
      .fwd_ready   (bus.fwd_ready),
      .fwd_data    (bus.fwd_data),
      .long_done   (bus.long_done),
      .long_rd     (bus.long_rd),
      .long_data   (bus.long_data),
      .src_out     (operand[i]),
      .sb_stall    (sb_hit[i]),
      .lu_stall    (lu_hit[i])
    );
  end

  always_comb begin
    any_sb      = 1'b0;
    any_lu      = 1'b0;
    bus.src_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_out[i*XLEN +: XLEN] = operand[i];
      any_sb = any_sb | sb_hit[i];
      any_lu = any_lu | lu_hit[i];
    end
  end

  // A writeback to the same rd this cycle frees the entry, so the new writer need not wait.
  always_comb begin
    waw = bus.issue_valid && bus.issue_we && (bus.issue_rd != 5'd0) &&
          pending_q[bus.issue_rd] && !(bus.long_done && (bus.long_rd == bus.issue_rd));
    struct_hit = bus.issue_valid && bus.issue_long &&
                 (long_count_q == CNT_W'(MAX_LONG)) && !bus.long_done;
    if (struct_hit)         cause = STRUCT;
    else if (any_sb || waw) cause = SCOREBOARD;
    else if (any_lu)        cause = LOAD_USE;
    else                    cause = NONE;
  end

  assign bus.stall        = (cause != NONE);
  assign bus.stall_cause  = cause;
  assign bus.long_count   = long_count_q;
  assign bus.stall_cycles = stall_cycles_q;

  assign acc = bus.issue_valid && !bus.stall && bus.issue_we && bus.issue_long &&
               (bus.issue_rd != 5'd0);
  assign ret = bus.long_done && (bus.long_rd != 5'd0) && pending_q[bus.long_rd];

  // Set is applied after clear so a re-issue to a just-retired rd keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (ret) pending_d[bus.long_rd] = 1'b0;
    if (acc) pending_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      long_count_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      pending_q    <= pending_d;
      long_count_q <= long_count_q + CNT_W'(acc) - CNT_W'(ret);
      if (bus.stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: combinational vector table followed by multi-cycle scoreboard sequences.
module tb_hazard_scoreboard;

  localparam int XLEN     = 32;
  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int MAX_LONG = 4;
  localparam int NVEC     = 10;

  localparam logic [31:0] RF0 = 32'h0000_A0A0;
  localparam logic [31:0] RF1 = 32'h0000_B1B1;

  typedef struct packed {
    logic [4:0]  idx0;
    logic [4:0]  idx1;
    logic [1:0]  sv;
    logic [1:0]  fv;
    logic [4:0]  fr0;
    logic [4:0]  fr1;
    logic [1:0]  frdy;
    logic        ld;
    logic [4:0]  lrd;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        chk0;
    logic        chk1;
    logic        es;
    logic [1:0]  ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];

  hazard_scoreboard_if #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MAX_LONG(MAX_LONG)
  ) bus ();

  hazard_scoreboard #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MAX_LONG(MAX_LONG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.issue_we    = 1'b0;
    bus.issue_long  = 1'b0;
    bus.src_valid   = 2'b00;
    bus.src_idx     = {5'd2, 5'd1};
    bus.src_rf_data = {RF1, RF0};
    bus.fwd_valid   = 2'b00;
    bus.fwd_rd      = '0;
    bus.fwd_ready   = 2'b00;
    bus.fwd_data    = {32'h0000_0022, 32'h0000_0011};
    bus.long_done   = 1'b0;
    bus.long_rd     = 5'd0;
    bus.long_data   = 32'h0000_0077;
  endtask

  task automatic issue_op(input logic [4:0] rd, input logic is_long);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_long  = is_long;
    bus.issue_rd    = rd;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive_idle();
    bus.src_idx   = {v.idx1, v.idx0};
    bus.src_valid = v.sv;
    bus.fwd_valid = v.fv;
    bus.fwd_rd    = {v.fr1, v.fr0};
    bus.fwd_ready = v.frdy;
    bus.long_done = v.ld;
    bus.long_rd   = v.lrd;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'd5, 5'd3, 2'b11, 2'b11, 5'd5, 5'd5, 2'b11, 1'b0, 5'd0, 32'h11,   RF1,    1'b1, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{5'd5, 5'd3, 2'b11, 2'b10, 5'd5, 5'd5, 2'b11, 1'b0, 5'd0, 32'h22,   RF1,    1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2] = '{5'd0, 5'd3, 2'b11, 2'b11, 5'd5, 5'd3, 2'b11, 1'b0, 5'd0, 32'h0,    32'h22, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{5'd1, 5'd7, 2'b11, 2'b01, 5'd7, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 2'd1};
    vecs[4] = '{5'd1, 5'd7, 2'b01, 2'b01, 5'd7, 5'd0, 2'b00, 1'b0, 5'd0, RF0,      32'h0,  1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5] = '{5'd4, 5'd3, 2'b11, 2'b01, 5'd4, 5'd0, 2'b01, 1'b1, 5'd4, 32'h77,   RF1,    1'b1, 1'b1, 1'b0, 2'd0};
    vecs[6] = '{5'd8, 5'd3, 2'b01, 2'b11, 5'd8, 5'd8, 2'b01, 1'b0, 5'd0, 32'h11,   RF1,    1'b1, 1'b1, 1'b0, 2'd0};
    vecs[7] = '{5'd8, 5'd3, 2'b11, 2'b11, 5'd8, 5'd8, 2'b10, 1'b0, 5'd0, 32'h0,    RF1,    1'b0, 1'b1, 1'b1, 2'd1};
    vecs[8] = '{5'd5, 5'd6, 2'b11, 2'b11, 5'd5, 5'd6, 2'b11, 1'b0, 5'd0, 32'h11,   32'h22, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[9] = '{5'd0, 5'd3, 2'b11, 2'b00, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 32'h0,    RF1,    1'b1, 1'b1, 1'b0, 2'd0};

    drive_idle();
    @(negedge clk);
    do_reset();
    #1;
    checkOutput("rst_count",  32'(bus.long_count), 32'd0);
    checkOutput("rst_cycles", bus.stall_cycles, 32'd0);
    checkOutput("rst_stall",  32'(bus.stall), 32'd0);
    checkOutput("rst_cause",  32'(bus.stall_cause), 32'd0);
    checkOutput("rst_out0",   bus.src_out[31:0], RF0);
    checkOutput("rst_out1",   bus.src_out[63:32], RF1);

    for (int n = 0; n < NVEC; n++) begin
      @(negedge clk);
      applyStimulus(vecs[n]);
      #1;
      checkOutput($sformatf("vec%0d_stall", n), 32'(bus.stall), 32'(vecs[n].es));
      checkOutput($sformatf("vec%0d_cause", n), 32'(bus.stall_cause), 32'(vecs[n].ec));
      if (vecs[n].chk0) checkOutput($sformatf("vec%0d_out0", n), bus.src_out[31:0], vecs[n].e0);
      if (vecs[n].chk1) checkOutput($sformatf("vec%0d_out1", n), bus.src_out[63:32], vecs[n].e1);
    end

    // Load-use stall, then the load data arrives.
    @(negedge clk);
    do_reset();
    bus.fwd_valid = 2'b01;
    bus.fwd_rd    = {5'd0, 5'd7};
    bus.fwd_ready = 2'b00;
    bus.src_idx   = {5'd7, 5'd1};
    bus.src_valid = 2'b10;
    #1;
    checkOutput("lu_stall",   32'(bus.stall), 32'd1);
    checkOutput("lu_cause",   32'(bus.stall_cause), 32'd1);
    checkOutput("lu_cyc0",    bus.stall_cycles, 32'd0);
    step();
    checkOutput("lu_cyc1",    bus.stall_cycles, 32'd1);
    bus.fwd_ready = 2'b01;
    bus.fwd_data  = {32'h0000_0022, 32'h0000_ABCD};
    #1;
    checkOutput("lu_out1",    bus.src_out[63:32], 32'h0000_ABCD);
    checkOutput("lu_release", 32'(bus.stall), 32'd0);
    step();
    checkOutput("lu_cyc_hold", bus.stall_cycles, 32'd1);

    // Scoreboard RAW on a multi-cycle result.
    drive_idle();
    issue_op(5'd9, 1'b1);
    step();
    drive_idle();
    checkOutput("sb_count1", 32'(bus.long_count), 32'd1);
    bus.src_idx   = {5'd2, 5'd9};
    bus.src_valid = 2'b01;
    #1;
    checkOutput("sb_stall",  32'(bus.stall), 32'd1);
    checkOutput("sb_cause",  32'(bus.stall_cause), 32'd2);
    step();
    bus.long_done = 1'b1;
    bus.long_rd   = 5'd9;
    bus.long_data = 32'h0000_1234;
    #1;
    checkOutput("sb_bypass", bus.src_out[31:0], 32'h0000_1234);
    checkOutput("sb_nostall", 32'(bus.stall), 32'd0);
    step();
    bus.long_done = 1'b0;
    #1;
    checkOutput("sb_count0", 32'(bus.long_count), 32'd0);
    checkOutput("sb_cleared", 32'(bus.stall), 32'd0);
    checkOutput("sb_rf",     bus.src_out[31:0], RF0);

    // Fill the long unit, then structural and WAW cases.
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_op(5'(r), 1'b1);
      step();
    end
    drive_idle();
    checkOutput("st_count4", 32'(bus.long_count), 32'd4);
    issue_op(5'd5, 1'b1);
    #1;
    checkOutput("st_cause",  32'(bus.stall_cause), 32'd3);
    step();
    checkOutput("st_hold4",  32'(bus.long_count), 32'd4);
    bus.long_done = 1'b1;
    bus.long_rd   = 5'd1;
    #1;
    checkOutput("st_retire_stall", 32'(bus.stall), 32'd0);
    step();
    drive_idle();
    checkOutput("st_swap4",  32'(bus.long_count), 32'd4);
    issue_op(5'd2, 1'b0);
    #1;
    checkOutput("waw_cause", 32'(bus.stall_cause), 32'd2);
    issue_op(5'd1, 1'b0);
    #1;
    checkOutput("waw_freed", 32'(bus.stall), 32'd0);
    issue_op(5'd2, 1'b1);
    #1;
    checkOutput("st_over_sb", 32'(bus.stall_cause), 32'd3);

    // Same-cycle retire and re-issue of one register; writeback to an idle register.
    @(negedge clk);
    do_reset();
    issue_op(5'd6, 1'b1);
    step();
    drive_idle();
    checkOutput("ss_count1", 32'(bus.long_count), 32'd1);
    issue_op(5'd6, 1'b1);
    bus.long_done = 1'b1;
    bus.long_rd   = 5'd6;
    #1;
    checkOutput("ss_nostall", 32'(bus.stall), 32'd0);
    step();
    drive_idle();
    checkOutput("ss_count_same", 32'(bus.long_count), 32'd1);
    bus.src_idx   = {5'd2, 5'd6};
    bus.src_valid = 2'b01;
    #1;
    checkOutput("ss_pending6", 32'(bus.stall_cause), 32'd2);
    drive_idle();
    bus.long_done = 1'b1;
    bus.long_rd   = 5'd12;
    step();
    drive_idle();
    checkOutput("ss_ignore12", 32'(bus.long_count), 32'd1);

    // Reset with work in flight.
    do_reset();
    issue_op(5'd10, 1'b1);
    step();
    issue_op(5'd11, 1'b1);
    step();
    issue_op(5'd13, 1'b1);
    step();
    drive_idle();
    checkOutput("mf_count3", 32'(bus.long_count), 32'd3);
    bus.src_idx   = {5'd2, 5'd10};
    bus.src_valid = 2'b01;
    for (int c = 0; c < 5; c++) step();
    checkOutput("mf_cycles5", bus.stall_cycles, 32'd5);
    do_reset();
    checkOutput("mf_count0",  32'(bus.long_count), 32'd0);
    checkOutput("mf_cycles0", bus.stall_cycles, 32'd0);
    bus.src_idx   = {5'd2, 5'd10};
    bus.src_valid = 2'b01;
    #1;
    checkOutput("mf_unpend",  32'(bus.stall), 32'd0);
    drive_idle();
    bus.long_done = 1'b1;
    bus.long_rd   = 5'd10;
    step();
    drive_idle();
    checkOutput("mf_late_done", 32'(bus.long_count), 32'd0);

    // Saturation of the stall counter.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    bus.fwd_valid = 2'b01;
    bus.fwd_rd    = {5'd0, 5'd7};
    bus.fwd_ready = 2'b00;
    bus.src_idx   = {5'd2, 5'd7};
    bus.src_valid = 2'b01;
    step();
    checkOutput("sat_reach", bus.stall_cycles, 32'hFFFF_FFFF);
    step();
    checkOutput("sat_hold",  bus.stall_cycles, 32'hFFFF_FFFF);

    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
